// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, owner
// codes and memory-direction codes.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ACESSO   = 2'd1,
      ESPERA   = 2'd2,
      RESPOSTA = 2'd3
   } estado_arb_t;

   localparam logic DONO_I    = 1'b0;
   localparam logic DONO_D    = 1'b1;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   // Wide enough for MEM_LAT - 1 with MEM_LAT up to 15.
   localparam int unsigned CONT_W = 4;

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Loadable down-counter that times the fixed memory latency; ZERO flags
// when the count has run out.
module mem_arb_lat_counter
   import mem_arb_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              LOAD,
   input  logic [CONT_W-1:0] LOAD_VAL,
   input  logic              DEC,
   output logic              ZERO
);

   logic [CONT_W-1:0] contagem;

   // Load has priority over decrement; the count saturates at zero.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         contagem <= '0;
      end else if (LOAD) begin
         contagem <= LOAD_VAL;
      end else if (DEC && (contagem != '0)) begin
         contagem <= contagem - 1'b1;
      end
   end

   assign ZERO = (contagem == '0);

endmodule

// File: rtl/arbitro_memoria.sv
// Arbiter and sequencer for the shared memory of the multicycle core.
// Grants the memory to the fetch (I) or data (D) requester, runs one
// fixed-latency transaction and returns a one-cycle VALID pulse.
// Optional macro MEM_ARB_FIXED_PRIO_EN: D always wins ties (no ULTIMO);
// default build uses round-robin on ties.
module arbitro_memoria
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              I_REQ,
   input  logic [ADDR_W-1:0] I_ADDR,
   output logic              I_GNT,
   output logic              I_VALID,
   output logic [DATA_W-1:0] I_RDATA,
   input  logic              D_REQ,
   input  logic              D_WE,
   input  logic [ADDR_W-1:0] D_ADDR,
   input  logic [DATA_W-1:0] D_WDATA,
   output logic              D_GNT,
   output logic              D_VALID,
   output logic [DATA_W-1:0] D_RDATA,
   output logic              MEM_EN,
   output logic              MEM_RW,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY,
   output logic [1:0]        ESTADO_ATUAL
);

   localparam logic [CONT_W-1:0] CARGA_LAT = CONT_W'(MEM_LAT - 1);

   estado_arb_t       estado, prox_estado;
   logic              dono_r, we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, i_rdata_r, d_rdata_r;
   logic              gnt_i, gnt_d, prefere_d;
   logic              carregar, decrementar, cont_zero;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign prefere_d = 1'b1;
`else
   logic ultimo;

   // Remember who was served last so the other side wins the next tie.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ultimo <= DONO_I;
      end else if (estado == RESPOSTA) begin
         ultimo <= dono_r;
      end
   end

   assign prefere_d = (ultimo == DONO_I);
`endif

   // Arbitration: only in OCIOSO; a lone requester always wins.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      if (estado == OCIOSO) begin
         gnt_d = D_REQ && (!I_REQ || prefere_d);
         gnt_i = I_REQ && !gnt_d;
      end
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         estado <= OCIOSO;
      end else begin
         estado <= prox_estado;
      end
   end

   // Next-state logic and latency-counter control.
   always_comb begin
      prox_estado = estado;
      carregar    = 1'b0;
      decrementar = 1'b0;
      case (estado)
         OCIOSO:   if (gnt_i || gnt_d) prox_estado = ACESSO;
         ACESSO: begin
            carregar    = 1'b1;
            prox_estado = ESPERA;
         end
         ESPERA: begin
            if (cont_zero) prox_estado = RESPOSTA;
            else           decrementar = 1'b1;
         end
         RESPOSTA: prox_estado = OCIOSO;
         default:  prox_estado = OCIOSO;
      endcase
   end

   mem_arb_lat_counter u_lat_counter (
      .CLK      (CLK),
      .RESET    (RESET),
      .LOAD     (carregar),
      .LOAD_VAL (CARGA_LAT),
      .DEC      (decrementar),
      .ZERO     (cont_zero)
   );

   // Latch owner and request fields at grant; held until the next grant.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         dono_r  <= DONO_I;
         we_r    <= MEM_READ;
         addr_r  <= '0;
         wdata_r <= '0;
      end else if (gnt_i || gnt_d) begin
         dono_r  <= gnt_d ? DONO_D : DONO_I;
         we_r    <= gnt_d ? D_WE : MEM_READ;
         addr_r  <= gnt_d ? D_ADDR : I_ADDR;
         wdata_r <= gnt_d ? D_WDATA : '0;
      end
   end

   // Capture read data into the owner's register as ESPERA ends.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         i_rdata_r <= '0;
         d_rdata_r <= '0;
      end else if ((estado == ESPERA) && cont_zero && (we_r == MEM_READ)) begin
         if (dono_r == DONO_I) i_rdata_r <= MEM_RDATA;
         else                  d_rdata_r <= MEM_RDATA;
      end
   end

   assign I_GNT        = gnt_i;
   assign D_GNT        = gnt_d;
   assign I_VALID      = (estado == RESPOSTA) && (dono_r == DONO_I);
   assign D_VALID      = (estado == RESPOSTA) && (dono_r == DONO_D);
   assign I_RDATA      = i_rdata_r;
   assign D_RDATA      = d_rdata_r;
   assign MEM_EN       = (estado == ACESSO);
   assign MEM_RW       = (estado == ACESSO) && we_r;
   assign MEM_ADDR     = addr_r;
   assign MEM_WDATA    = wdata_r;
   assign BUSY         = (estado != OCIOSO);
   assign ESTADO_ATUAL = estado;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Self-checking bench for arbitro_memoria (MEM_LAT = 2). Expected read
// results are queued when a request is driven and popped on VALID.
module tb_arbitro_memoria;
   import mem_arb_pkg::*;

   localparam int unsigned MEM_LAT = 2;

   logic        CLK, RESET;
   logic        I_REQ, I_GNT, I_VALID;
   logic [63:0] I_ADDR, I_RDATA;
   logic        D_REQ, D_WE, D_GNT, D_VALID;
   logic [63:0] D_ADDR, D_WDATA, D_RDATA;
   logic        MEM_EN, MEM_RW, BUSY;
   logic [63:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic [1:0]  ESTADO_ATUAL;

   typedef struct {
      logic        dono;
      logic [63:0] data;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] held_i = '0;
   logic [63:0] held_d = '0;
   logic [15:0] en_pipe;

   arbitro_memoria #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_VALID(I_VALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_VALID(D_VALID), .D_RDATA(D_RDATA),
      .MEM_EN(MEM_EN), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .ESTADO_ATUAL(ESTADO_ATUAL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [63:0] mem_word(input logic [63:0] a);
      if (a == 64'h10) return 64'h0000_0000_00A0_0093;
      return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   // Memory model: read data is valid only in the cycle MEM_LAT cycles
   // after the MEM_EN read strobe, garbage otherwise.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) en_pipe <= '0;
      else       en_pipe <= {en_pipe[14:0], MEM_EN && !MEM_RW};
   end
   assign MEM_RDATA = en_pipe[MEM_LAT-1] ? mem_word(MEM_ADDR) : 64'hBAD0_BAD0_BAD0_BAD0;

   task automatic test_reset();
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      checks++;
      if ({I_GNT, I_VALID, D_GNT, D_VALID, MEM_EN, MEM_RW, BUSY} !== 7'b0 || ESTADO_ATUAL !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl: gnt/valid/en/rw/busy=%b estado=%0d, want 0 and 0",
                  {I_GNT, I_VALID, D_GNT, D_VALID, MEM_EN, MEM_RW, BUSY}, ESTADO_ATUAL);
      end
      checks++;
      if (I_RDATA !== '0 || D_RDATA !== '0 || MEM_ADDR !== '0 || MEM_WDATA !== '0) begin
         errors++;
         $display("FAIL reset_data: I_RDATA=%h D_RDATA=%h MEM_ADDR=%h MEM_WDATA=%h, want all 0",
                  I_RDATA, D_RDATA, MEM_ADDR, MEM_WDATA);
      end
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || ESTADO_ATUAL !== 2'd0) begin
         errors++;
         $display("FAIL reset_release: BUSY=%b estado=%0d, want 0 0", BUSY, ESTADO_ATUAL);
      end
   endtask

`ifndef MEM_ARB_FIXED_PRIO_EN
   task automatic test_round_robin();
      exp_t e;
      logic [1:0] eg, ev;
      for (int c = 0; c <= 14; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin
            I_REQ = 1'b1; I_ADDR = 64'h44;
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h40;
            sb.push_back('{dono: DONO_D, data: mem_word(64'h40)}); held_d = mem_word(64'h40);
         end
         if (c == 1) D_ADDR = 64'h48;
         if (c == 5) begin sb.push_back('{dono: DONO_I, data: mem_word(64'h44)}); held_i = mem_word(64'h44); end
         if (c == 10) begin sb.push_back('{dono: DONO_D, data: mem_word(64'h48)}); held_d = mem_word(64'h48); end
         if (c == 11) begin I_REQ = 1'b0; D_REQ = 1'b0; end
         @(negedge CLK);
         eg = (c == 5) ? 2'b10 : ((c == 0 || c == 10) ? 2'b01 : 2'b00);
         ev = (c == 9) ? 2'b10 : ((c == 4 || c == 14) ? 2'b01 : 2'b00);
         checks++;
         if ({I_GNT, D_GNT} !== eg) begin
            errors++;
            $display("FAIL rr_gnt c%0d: {I_GNT,D_GNT}=%b, want %b", c, {I_GNT, D_GNT}, eg);
         end
         checks++;
         if ({I_VALID, D_VALID} !== ev) begin
            errors++;
            $display("FAIL rr_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, ev);
         end
         if (I_VALID || D_VALID) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL rr_sb c%0d: VALID with empty scoreboard, want no VALID", c);
            end else begin
               e = sb.pop_front();
               if (D_VALID !== e.dono || (D_VALID ? D_RDATA : I_RDATA) !== e.data) begin
                  errors++;
                  $display("FAIL rr_data c%0d: owner=%b rdata=%h, want owner=%b rdata=%h",
                           c, D_VALID, D_VALID ? D_RDATA : I_RDATA, e.dono, e.data);
               end
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rr_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask
`else
   task automatic test_fixed_prio();
      exp_t e;
      logic [1:0] eg, ev;
      for (int c = 0; c <= 14; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin
            I_REQ = 1'b1; I_ADDR = 64'h44;
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h40;
         end
         if (c == 0 || c == 5 || c == 10) begin
            sb.push_back('{dono: DONO_D, data: mem_word(64'h40)}); held_d = mem_word(64'h40);
         end
         if (c == 11) begin I_REQ = 1'b0; D_REQ = 1'b0; end
         @(negedge CLK);
         eg = (c == 0 || c == 5 || c == 10) ? 2'b01 : 2'b00;
         ev = (c == 4 || c == 9 || c == 14) ? 2'b01 : 2'b00;
         checks++;
         if ({I_GNT, D_GNT} !== eg) begin
            errors++;
            $display("FAIL fp_gnt c%0d: {I_GNT,D_GNT}=%b, want %b", c, {I_GNT, D_GNT}, eg);
         end
         checks++;
         if ({I_VALID, D_VALID} !== ev) begin
            errors++;
            $display("FAIL fp_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, ev);
         end
         if (D_VALID && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (D_RDATA !== e.data) begin
               errors++;
               $display("FAIL fp_data c%0d: D_RDATA=%h, want %h", c, D_RDATA, e.data);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL fp_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask
`endif

   task automatic test_fetch();
      exp_t e;
      logic [1:0] est;
      for (int c = 0; c <= 6; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin
            I_REQ = 1'b1; I_ADDR = 64'h10;
            sb.push_back('{dono: DONO_I, data: mem_word(64'h10)}); held_i = mem_word(64'h10);
         end
         if (c == 1) I_REQ = 1'b0;
         @(negedge CLK);
         est = (c == 0) ? 2'd0 : (c == 1) ? 2'd1 : (c <= 3) ? 2'd2 : (c == 4) ? 2'd3 : 2'd0;
         checks++;
         if (ESTADO_ATUAL !== est || BUSY !== (est != 2'd0)) begin
            errors++;
            $display("FAIL fetch_state c%0d: estado=%0d BUSY=%b, want %0d %b", c, ESTADO_ATUAL, BUSY, est, est != 2'd0);
         end
         if (c == 0) begin
            checks++;
            if (I_GNT !== 1'b1 || D_GNT !== 1'b0) begin
               errors++;
               $display("FAIL fetch_gnt: I_GNT=%b D_GNT=%b, want 1 0", I_GNT, D_GNT);
            end
         end
         checks++;
         if (MEM_EN !== (c == 1) || (c == 1 && (MEM_RW !== 1'b0 || MEM_ADDR !== 64'h10))) begin
            errors++;
            $display("FAIL fetch_mem c%0d: EN=%b RW=%b ADDR=%h, want EN=%b RW=0 ADDR=10", c, MEM_EN, MEM_RW, MEM_ADDR, c == 1);
         end
         checks++;
         if ({I_VALID, D_VALID} !== ((c == 4) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL fetch_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, (c == 4) ? 2'b10 : 2'b00);
         end
         if (I_VALID && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (I_RDATA !== e.data || e.dono !== DONO_I) begin
               errors++;
               $display("FAIL fetch_data: I_RDATA=%h, want %h", I_RDATA, e.data);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL fetch_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_write();
      exp_t e;
      for (int c = 0; c <= 6; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin
            D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 64'h20; D_WDATA = 64'hDEAD_BEEF;
            sb.push_back('{dono: DONO_D, data: held_d});
         end
         if (c == 1) begin D_REQ = 1'b0; D_WE = 1'b0; D_WDATA = '0; end
         @(negedge CLK);
         if (c == 0) begin
            checks++;
            if (D_GNT !== 1'b1 || I_GNT !== 1'b0) begin
               errors++;
               $display("FAIL write_gnt: D_GNT=%b I_GNT=%b, want 1 0", D_GNT, I_GNT);
            end
         end
         if (c >= 1 && c <= 4) begin
            checks++;
            if (MEM_EN !== (c == 1) || MEM_RW !== (c == 1) || MEM_ADDR !== 64'h20 || MEM_WDATA !== 64'hDEAD_BEEF) begin
               errors++;
               $display("FAIL write_mem c%0d: EN=%b RW=%b ADDR=%h WDATA=%h, want EN=RW=%b ADDR=20 WDATA=deadbeef",
                        c, MEM_EN, MEM_RW, MEM_ADDR, MEM_WDATA, c == 1);
            end
         end
         checks++;
         if ({I_VALID, D_VALID} !== ((c == 4) ? 2'b01 : 2'b00)) begin
            errors++;
            $display("FAIL write_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, (c == 4) ? 2'b01 : 2'b00);
         end
         if (D_VALID && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (D_RDATA !== e.data) begin
               errors++;
               $display("FAIL write_rdata: D_RDATA=%h, want unchanged %h", D_RDATA, e.data);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL write_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      logic [1:0] eg, ev;
      for (int c = 0; c <= 10; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin
            I_REQ = 1'b1; I_ADDR = 64'h80;
            sb.push_back('{dono: DONO_I, data: mem_word(64'h80)}); held_i = mem_word(64'h80);
         end
         if (c == 1) I_REQ = 1'b0;
         if (c == 2) begin D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h88; end
         if (c == 3) D_REQ = 1'b0;
         if (c == 4) D_REQ = 1'b1;
         if (c == 5) begin sb.push_back('{dono: DONO_D, data: mem_word(64'h88)}); held_d = mem_word(64'h88); end
         if (c == 6) D_REQ = 1'b0;
         @(negedge CLK);
         eg = (c == 0) ? 2'b10 : ((c == 5) ? 2'b01 : 2'b00);
         ev = (c == 4) ? 2'b10 : ((c == 9) ? 2'b01 : 2'b00);
         checks++;
         if ({I_GNT, D_GNT} !== eg) begin
            errors++;
            $display("FAIL busy_gnt c%0d: {I_GNT,D_GNT}=%b, want %b", c, {I_GNT, D_GNT}, eg);
         end
         checks++;
         if ({I_VALID, D_VALID} !== ev) begin
            errors++;
            $display("FAIL busy_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, ev);
         end
         if ((I_VALID || D_VALID) && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (D_VALID !== e.dono || (D_VALID ? D_RDATA : I_RDATA) !== e.data) begin
               errors++;
               $display("FAIL busy_data c%0d: owner=%b rdata=%h, want owner=%b rdata=%h",
                        c, D_VALID, D_VALID ? D_RDATA : I_RDATA, e.dono, e.data);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL busy_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      for (int c = 0; c <= 11; c++) begin
         @(posedge CLK); #1;
         if (c == 0) begin I_REQ = 1'b1; I_ADDR = 64'h30; end
         if (c == 1) I_REQ = 1'b0;
         if (c == 3) begin RESET = 1'b1; held_i = '0; held_d = '0; end
         if (c == 5) RESET = 1'b0;
         if (c == 6) begin
            I_REQ = 1'b1; I_ADDR = 64'h10;
            sb.push_back('{dono: DONO_I, data: mem_word(64'h10)}); held_i = mem_word(64'h10);
         end
         if (c == 7) I_REQ = 1'b0;
         @(negedge CLK);
         if (c == 3) begin
            checks++;
            if ({MEM_EN, I_VALID, D_VALID, I_GNT, D_GNT, BUSY} !== 6'b0 || ESTADO_ATUAL !== 2'd0 ||
                MEM_ADDR !== '0 || I_RDATA !== '0 || D_RDATA !== '0) begin
               errors++;
               $display("FAIL rstmid_outputs: ctrl=%b estado=%0d ADDR=%h I_RDATA=%h D_RDATA=%h, want all 0",
                        {MEM_EN, I_VALID, D_VALID, I_GNT, D_GNT, BUSY}, ESTADO_ATUAL, MEM_ADDR, I_RDATA, D_RDATA);
            end
         end
         if (c == 6) begin
            checks++;
            if (I_GNT !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: I_GNT=%b, want 1", I_GNT); end
         end
         checks++;
         if ({I_VALID, D_VALID} !== ((c == 10) ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL rstmid_valid c%0d: {I_VALID,D_VALID}=%b, want %b", c, {I_VALID, D_VALID}, (c == 10) ? 2'b10 : 2'b00);
         end
         if (I_VALID && sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (I_RDATA !== e.data) begin
               errors++;
               $display("FAIL rstmid_data: I_RDATA=%h, want %h", I_RDATA, e.data);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL rstmid_left: %0d pending, want 0", sb.size()); sb.delete(); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1;
      I_REQ = 1'b0; I_ADDR = '0;
      D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
      test_reset();
`ifndef MEM_ARB_FIXED_PRIO_EN
      test_round_robin();
`else
      test_fixed_prio();
`endif
      test_fetch();
      test_write();
      test_busy_ignore();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
